// File: rtl/issue_ctrl.sv
// ---------------------------------------------------------------------------
// issue_ctrl
//   Dual-issue scheduler sitting between decode and execute. Decoded
//   instructions are buffered in a circular queue; every cycle the two head
//   entries are examined and 0, 1 or 2 of them are issued in program order.
//   The block also owns the mul/div busy counter that gates HI/LO traffic.
//
//   Configuration macro: ISSUE_DUAL_EN
//     defined   -> slot 1 may issue alongside slot 0 (dual issue)
//     undefined -> issue_valid[1] is tied 0, one instruction per cycle
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   flush             drop every queued entry at the next edge
//   in_valid[1:0]     enqueue request per decode lane (lane 1 needs lane 0)
//   in_ready          queue has at least two free entries
//   in_ra1/in_ra2     source registers, lane i at [5*i +: 5]
//   in_dst            destination register, lane i at [5*i +: 5]
//   in_flags          {regwrite,is_mem,is_branch,is_muldiv,hilo_read,cp0_read}
//                     per lane, lane i at [6*i +: 6]
//   in_payload        opaque payload, lane i at [PAYLOAD_W*i +: PAYLOAD_W]
//   head_ra1/ra2/flags  head 0/1 fields for the forwarding unit
//   byp_valid[1:0]    operands of head i resolvable this cycle
//   ex_ready          execute accepts an issue group this cycle
//   issue_valid[1:0]  slot 0/1 issuing (slot 1 implies slot 0)
//   issue_payload     head payloads, slot i at [PAYLOAD_W*i +: PAYLOAD_W]
//   muldiv_busy       mul/div busy counter is nonzero
// ---------------------------------------------------------------------------
module issue_ctrl #(
    parameter int DEPTH      = 8,
    parameter int PAYLOAD_W  = 96,
    parameter int MULDIV_LAT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [1:0]             in_valid,
    output logic                   in_ready,
    input  logic [9:0]             in_ra1,
    input  logic [9:0]             in_ra2,
    input  logic [9:0]             in_dst,
    input  logic [11:0]            in_flags,
    input  logic [2*PAYLOAD_W-1:0] in_payload,
    output logic [9:0]             head_ra1,
    output logic [9:0]             head_ra2,
    output logic [11:0]            head_flags,
    input  logic [1:0]             byp_valid,
    input  logic                   ex_ready,
    output logic [1:0]             issue_valid,
    output logic [2*PAYLOAD_W-1:0] issue_payload,
    output logic                   muldiv_busy
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BUSY_W = $clog2(MULDIV_LAT + 1);

    localparam int F_MULDIV = 2;
    localparam int F_HILO   = 1;

    logic [PTR_W-1:0]     head_ptr;
    logic [PTR_W-1:0]     tail_ptr;
    logic [CNT_W-1:0]     count;
    logic [BUSY_W-1:0]    busy_cnt;

    logic [4:0]           mem_ra1     [DEPTH];
    logic [4:0]           mem_ra2     [DEPTH];
    logic [4:0]           mem_dst     [DEPTH];
    logic [5:0]           mem_flags   [DEPTH];
    logic [PAYLOAD_W-1:0] mem_payload [DEPTH];

    logic [PTR_W-1:0]     head1_ptr;
    logic [PTR_W-1:0]     tail1_ptr;
    logic [5:0]           h0_flags;
    logic [5:0]           h1_flags;
    logic [4:0]           h0_dst;
    logic [4:0]           h1_ra1;
    logic [4:0]           h1_ra2;
    logic                 enq0;
    logic                 enq1;
    logic [1:0]           enq_num;
    logic [1:0]           iss_num;
    logic                 can0;
    logic                 can1;
    logic                 md_issue;

    assign head1_ptr = head_ptr + PTR_W'(1);
    assign tail1_ptr = tail_ptr + PTR_W'(1);

    assign h0_flags = mem_flags[head_ptr];
    assign h1_flags = mem_flags[head1_ptr];
    assign h0_dst   = mem_dst[head_ptr];
    assign h1_ra1   = mem_ra1[head1_ptr];
    assign h1_ra2   = mem_ra2[head1_ptr];

    assign head_ra1      = {h1_ra1, mem_ra1[head_ptr]};
    assign head_ra2      = {h1_ra2, mem_ra2[head_ptr]};
    assign head_flags    = {h1_flags, h0_flags};
    assign issue_payload = {mem_payload[head1_ptr], mem_payload[head_ptr]};

    // in_ready looks only at the current count, so a two-lane enqueue can
    // never overrun the queue even if nothing issues in the same cycle.
    assign in_ready = (count <= CNT_W'(DEPTH - 2));
    assign enq0     = in_ready & in_valid[0];
    assign enq1     = enq0 & in_valid[1];
    assign enq_num  = {1'b0, enq0} + {1'b0, enq1};

    assign muldiv_busy = (busy_cnt != '0);

    // Slot 0 eligibility: a mul/div or HI/LO reader must wait for the
    // mul/div unit to drain.
    always_comb begin
        can0 = 1'b0;
        if (count != '0 && byp_valid[0] && ex_ready)
            can0 = !(muldiv_busy && (h0_flags[F_MULDIV] || h0_flags[F_HILO]));
    end

`ifdef ISSUE_DUAL_EN
    localparam int F_REGWRITE = 5;
    localparam int F_MEM      = 4;
    localparam int F_BRANCH   = 3;
    localparam int F_CP0      = 0;

    // Slot 1 pairs with slot 0 only when no intra-pair hazard exists:
    // RAW on head 0, two memory ops, a branch in slot 1, two HI/LO users,
    // or a CP0 read behind a mul/div.
    always_comb begin
        can1 = 1'b0;
        if (can0 && count >= CNT_W'(2) && byp_valid[1]) begin
            can1 = 1'b1;
            if (h0_flags[F_REGWRITE] && h0_dst != 5'd0 &&
                (h0_dst == h1_ra1 || h0_dst == h1_ra2))
                can1 = 1'b0;
            if (h0_flags[F_MEM] && h1_flags[F_MEM])
                can1 = 1'b0;
            if (h1_flags[F_BRANCH])
                can1 = 1'b0;
            if ((h0_flags[F_MULDIV] || h0_flags[F_HILO]) &&
                (h1_flags[F_MULDIV] || h1_flags[F_HILO]))
                can1 = 1'b0;
            if (h1_flags[F_CP0] && h0_flags[F_MULDIV])
                can1 = 1'b0;
        end
    end
`else
    logic dual_unused;
    assign dual_unused = ^{byp_valid[1], h0_dst};
    assign can1        = 1'b0;
`endif

    assign issue_valid = {can1, can0};
    assign iss_num     = {1'b0, can0} + {1'b0, can1};
    assign md_issue    = (can0 & h0_flags[F_MULDIV]) | (can1 & h1_flags[F_MULDIV]);

    // Queue pointers and occupancy. A flush empties the queue by snapping
    // head onto the pre-edge tail, discarding any same-cycle enqueue/issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= tail_ptr;
            count    <= '0;
        end else begin
            head_ptr <= head_ptr + PTR_W'(iss_num);
            tail_ptr <= tail_ptr + PTR_W'(enq_num);
            count    <= count + CNT_W'(enq_num) - CNT_W'(iss_num);
        end
    end

    // Entry storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (enq0 && !flush) begin
            mem_ra1[tail_ptr]     <= in_ra1[4:0];
            mem_ra2[tail_ptr]     <= in_ra2[4:0];
            mem_dst[tail_ptr]     <= in_dst[4:0];
            mem_flags[tail_ptr]   <= in_flags[5:0];
            mem_payload[tail_ptr] <= in_payload[PAYLOAD_W-1:0];
        end
        if (enq1 && !flush) begin
            mem_ra1[tail1_ptr]     <= in_ra1[9:5];
            mem_ra2[tail1_ptr]     <= in_ra2[9:5];
            mem_dst[tail1_ptr]     <= in_dst[9:5];
            mem_flags[tail1_ptr]   <= in_flags[11:6];
            mem_payload[tail1_ptr] <= in_payload[2*PAYLOAD_W-1:PAYLOAD_W];
        end
    end

    // Busy counter keeps running through a flush so an in-flight mul/div
    // still blocks HI/LO access until it completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            busy_cnt <= '0;
        else if (md_issue)
            busy_cnt <= BUSY_W'(MULDIV_LAT);
        else if (busy_cnt != '0)
            busy_cnt <= busy_cnt - BUSY_W'(1);
    end

endmodule
